ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
// - Bitstream writer for the configuration-chain (ccff) shift path; the driving end of the ccff_head -> ccff_tail chain through the tiles.
// - Accepts a word stream and serialises it LSB-first onto ccff_head with config_enable as the shift qualifier.
// - Optional verify pass: the same bitstream is streamed a second time, and ccff_tail is compared bit-for-bit against the bits being shifted in.
// - Sits beside the fabric top, in the prog_clk domain.
// PARAMETERS
// - CHAIN_LEN  1024  number of ccff flops in the chain (>=1)
// - WORD_W     32    bitstream word width (>=1)
// - CNT_W      16    mismatch counter width
// PORTS
// - prog_clk        in   1          programming clock; all state on rising edge
// - pReset_n        in   1          asynchronous active-low reset
// - start           in   1          1-cycle pulse; begins load; ignored unless IDLE
// - verify_en       in   1          sampled with start; 1 = run verify pass after load
// - word_valid      in   1          bitstream word available
// - word_data       in   WORD_W     bitstream word, bit 0 shifted first
// - word_ready      out  1          word accepted when word_valid & word_ready
// - ccff_head       out  1          serial data into chain (registered)
// - ccff_tail       in   1          serial data out of chain (flop output, no comb path)
// - config_enable   out  1          chain shifts on prog_clk edge when 1 (registered)
// - busy            out  1          high outside IDLE
// - done            out  1          1-cycle pulse at end of operation
// - verify_fail     out  1          sticky; cleared by next accepted start
// - mismatch_cnt    out  CNT_W      saturating count of verify mismatches; cleared by start
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; word buffer empty; counters 0.
// - States: IDLE -> LOAD -> (VERIFY if verify_en) -> DRAIN -> DONE -> IDLE.
// - Word buffer: one WORD_W shift register plus bit index.
//   - word_ready = busy & state in {LOAD, VERIFY} & (buffer empty | last bit of buffer issuing this cycle), so back-to-back words give gap-free shifting.
// - Issue cycle: buffer holds a bit and pass bit count < CHAIN_LEN.
//   - Register ccff_head <= bit, config_enable <= 1.
//   - Otherwise config_enable <= 0, ccff_head holds its value; the chain freezes, no data loss.
// - Each pass issues exactly CHAIN_LEN bits and starts on a word boundary; unused high bits of the final word (CHAIN_LEN mod WORD_W) are discarded.
// - The pass bit counter wraps to 0 between LOAD and VERIFY; each pass consumes ceil(CHAIN_LEN/WORD_W) words.
// - Verify compare, during VERIFY only: at each prog_clk edge with config_enable=1, ccff_tail != ccff_head is a mismatch.
//   - The tail then presents the bit pushed CHAIN_LEN shifts earlier, i.e. the same-index bit from LOAD.
//   - A mismatch sets verify_fail and increments mismatch_cnt, which saturates at all-ones.
// - DRAIN: entered after the last bit of the final pass is issued; waits one cycle so the final shift edge (and its compare) completes, with config_enable 0.
// - DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle done rises.
// - start while busy: ignored. word_valid in IDLE: not accepted (word_ready=0).
// - Async reset mid-operation: immediate return to IDLE and outputs 0.
//   - The chain holds a partial image; software must restart from word 0.
// - Latency: the first ccff shift edge occurs 2 edges after start when word_valid is already high (accept, then issue).
// STRUCTURE
// - Shared package ccff_loader_pkg: state enum (IDLE, LOAD, VERIFY, DRAIN, DONE) and localparams for words-per-pass and tail-bit count.
// - One sub-module: ccff_word_serializer (word buffer, bit index, ready/issue logic). FSM, pass counter and comparator live in ccff_chain_loader.
// - Bench models the chain as a CHAIN_LEN-deep shift register clocked by prog_clk, gated by config_enable.
// TESTING
// - T1: CHAIN_LEN=40, WORD_W=32, verify_en=0, words 0xA5A5A5A5, 0x000000FF -> exactly 40 shift edges; chain = 0xFF_A5A5A5A5 (bit 0 at tail); 2 words accepted; done once; verify_fail=0.
// - T2: same words streamed twice with verify_en=1 -> 80 shift edges, mismatch_cnt=0, verify_fail=0, done 1 cycle after last shift.
// - T3: as T2, but bench flips chain bit 7 after LOAD -> mismatch_cnt=1, verify_fail=1; a new start clears both.
// - T4: word_valid dropped for 5 cycles mid-word-2 -> config_enable=0 for those cycles, ccff_head stable, final image identical to T1.
// - T5: CNT_W=2, all verify bits corrupted -> mismatch_cnt saturates at 3, no wrap.
// - T6: pReset_n pulsed low mid-LOAD -> busy, config_enable, ccff_head, done all 0 immediately; start ignored while busy in a separate run.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared types and helpers for the configuration-chain loader.
//               Holds the loader state encoding and the pass-geometry helpers
//               used to size one chain pass in bitstream words.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bitstream words needed to cover one full pass of the chain.
    function automatic int words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits used from the final word of a pass; 0 means the final word is full.
    function automatic int tail_bits(input int chain_len, input int word_w);
        return chain_len % word_w;
    endfunction

    // Bit-index width for a word buffer, never below one bit.
    function automatic int idx_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ccff_word_serializer
// Description : Single-word buffer that presents a bitstream word LSB-first.
//               A load replaces the buffer contents; each issue advances one
//               bit, and the buffer empties after its last bit or on a flush
//               (end of pass, discarding unused high bits).
// Ports       : i_clk/i_rst_n  clock, async active-low reset
//               i_load/i_data  load a new word (takes priority over issue)
//               i_issue        current bit is consumed this cycle
//               i_flush        with i_issue: drop remaining bits of the word
//               o_has_bit      buffer holds an unissued bit
//               o_bit          bit currently presented
//               o_last         presented bit is the top bit of the word
//               o_idx          index of the presented bit within the word
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int IDX_W  = idx_width(WORD_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_issue,
    input  logic              i_flush,
    output logic              o_has_bit,
    output logic              o_bit,
    output logic              o_last,
    output logic [IDX_W-1:0]  o_idx
);

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_has_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_has_bit <= 1'b0;
        end else if (i_load) begin
            r_buf     <= i_data;
            r_idx     <= '0;
            r_has_bit <= 1'b1;
        end else if (i_issue) begin
            if (o_last || i_flush) begin
                r_has_bit <= 1'b0;
            end else begin
                r_buf <= r_buf >> 1;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_has_bit = r_has_bit;
    assign o_bit     = r_buf[0];
    assign o_last    = (r_idx == IDX_W'(WORD_W - 1));
    assign o_idx     = r_idx;

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Driving end of the ccff configuration chain. Serialises a
//               word stream LSB-first onto ccff_head, qualified by
//               config_enable, and optionally streams the bitstream again
//               while comparing ccff_tail against the bits shifted in.
// Ports       : prog_clk, pReset_n        clock, async active-low reset
//               start, verify_en          begin a load (verify pass optional)
//               word_valid/word_data/word_ready  bitstream word handshake
//               ccff_head, config_enable  registered chain drive
//               ccff_tail                 chain output, compared in verify
//               busy, done                operation status
//               verify_fail, mismatch_cnt verify result (cleared by start)
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              verify_fail,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    localparam int c_WPP    = words_per_pass(CHAIN_LEN, WORD_W);
    localparam int c_TAIL   = tail_bits(CHAIN_LEN, WORD_W);
    localparam int c_IDX_W  = idx_width(WORD_W);
    localparam int c_WCNT_W = (c_WPP > 1) ? $clog2(c_WPP) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'((c_TAIL == 0) ? WORD_W - 1 : c_TAIL - 1);
    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(c_WPP - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_verify_mode;
    logic                r_head;
    logic                r_cfg_en;
    logic                r_cmp_en;
    logic                r_fail;
    logic [CNT_W-1:0]    r_mism_cnt;
    logic [c_WCNT_W-1:0] r_word_cnt;

    logic                w_has_bit;
    logic                w_bit;
    logic                w_last;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_active;
    logic                w_issue;
    logic                w_pass_end;
    logic                w_word_done;
    logic                w_final;
    logic                w_ready_cond;
    logic                w_load;
    logic                w_start_acc;
    logic                w_mismatch;

    // The pass position is tracked as (word in pass, bit in word); the pass
    // ends on the last used bit of the final word, so a pass is exactly
    // CHAIN_LEN issues and always restarts on a word boundary.
    assign w_active    = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign w_issue     = w_active && w_has_bit;
    assign w_pass_end  = w_issue && (r_word_cnt == c_LAST_WORD) && (w_idx == c_LAST_IDX);
    assign w_word_done = w_issue && (w_last || w_pass_end);
    // The final bit of the whole operation must not pull in another word.
    assign w_final     = w_pass_end && ((r_state == ST_VERIFY) || !r_verify_mode);
    assign w_ready_cond = !w_has_bit || (w_word_done && !w_final);
    assign w_load      = word_valid && word_ready;
    assign w_start_acc = (r_state == ST_IDLE) && start;
    // r_cmp_en marks shift edges carrying verify-pass bits; this keeps the
    // last LOAD shift out of the compare and includes the last VERIFY shift
    // that completes while in DRAIN.
    assign w_mismatch  = r_cfg_en && r_cmp_en && (ccff_tail != r_head);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .i_clk     (prog_clk),
        .i_rst_n   (pReset_n),
        .i_load    (w_load),
        .i_data    (word_data),
        .i_issue   (w_issue),
        .i_flush   (w_pass_end),
        .o_has_bit (w_has_bit),
        .o_bit     (w_bit),
        .o_last    (w_last),
        .o_idx     (w_idx)
    );

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        word_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                word_ready = w_ready_cond;
                if (w_pass_end) w_state_nxt = r_verify_mode ? ST_VERIFY : ST_DRAIN;
            end
            ST_VERIFY: begin
                busy       = 1'b1;
                word_ready = w_ready_cond;
                if (w_pass_end) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_head        <= 1'b0;
            r_cfg_en      <= 1'b0;
            r_cmp_en      <= 1'b0;
            r_verify_mode <= 1'b0;
            r_fail        <= 1'b0;
            r_mism_cnt    <= '0;
            r_word_cnt    <= '0;
        end else begin
            r_cfg_en <= w_issue;
            r_cmp_en <= w_issue && (r_state == ST_VERIFY);
            if (w_issue) r_head <= w_bit;

            if (w_start_acc) begin
                r_verify_mode <= verify_en;
                r_fail        <= 1'b0;
                r_mism_cnt    <= '0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
                if (r_mism_cnt != '1) r_mism_cnt <= r_mism_cnt + 1'b1;
            end

            if (w_start_acc || w_pass_end) begin
                r_word_cnt <= '0;
            end else if (w_word_done) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign ccff_head     = r_head;
    assign config_enable = r_cfg_en;
    assign verify_fail   = r_fail;
    assign mismatch_cnt  = r_mism_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Self-checking bench for ccff_chain_loader with a behavioural
//               CHAIN_LEN-deep chain model (tail at index 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int L    = 40;
    localparam int W    = 32;
    localparam int CW   = 2;
    localparam int NWPP = (L + W - 1) / W;

    logic          prog_clk   = 1'b0;
    logic          pReset_n   = 1'b0;
    logic          start      = 1'b0;
    logic          verify_en  = 1'b0;
    logic          word_valid = 1'b0;
    logic [W-1:0]  word_data  = '0;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          config_enable;
    logic          busy;
    logic          done;
    logic          verify_fail;
    logic [CW-1:0] mismatch_cnt;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(CW)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .verify_en     (verify_en),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .verify_fail   (verify_fail),
        .mismatch_cnt  (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: new bits enter at the top, ccff_tail is chain[0].
    logic [L-1:0] chain = '0;
    logic [L-1:0] chain_nxt;
    int  flip_token  = 0;
    int  flip_seen   = 0;
    bit  corrupt_all = 1'b0;
    int  shift_cnt   = 0;
    int  done_cnt    = 0;
    int  acc_cnt     = 0;

    assign ccff_tail = chain[0] ^ corrupt_all;

    always @(posedge prog_clk) begin
        chain_nxt = chain;
        if (flip_token != flip_seen) chain_nxt[7] = ~chain_nxt[7];
        if (config_enable) chain_nxt = {ccff_head, chain_nxt[L-1:1]};
        chain     <= chain_nxt;
        flip_seen <= flip_token;
        shift_cnt <= shift_cnt + (config_enable ? 1 : 0);
        done_cnt  <= done_cnt + (done ? 1 : 0);
        acc_cnt   <= acc_cnt + ((word_valid && word_ready) ? 1 : 0);
    end

    int checks = 0;
    int errors = 0;

    logic [W-1:0] op_words [4];
    int  g_acc, g_shifts, g_dones, g_first_en, g_last_en, g_done_k, g_lows;
    bit  g_timeout, g_head_moved, g_busy_at_done, g_pre_en;
    logic [CW-1:0] g_cnt_start;
    logic          g_fail_start;
    logic [4:0]    g_rst_snap;

    function automatic logic stream_bit(input int pass, input int i);
        logic [W-1:0] w;
        w = op_words[pass * NWPP + i / W];
        return w[i % W];
    endfunction

    function automatic logic [L-1:0] exp_image(input int pass);
        logic [L-1:0] img;
        for (int i = 0; i < L; i++) img[i] = stream_bit(pass, i);
        return img;
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Runs one operation: start pulse, word feed with optional hold/gaps,
    // optional extra start or async reset at loop iteration k.
    task automatic drive_op(input bit ver, input int nwords, input int hold_idx,
                            input int hold_len, input int gap_pct,
                            input int restart_at, input int reset_at);
        int idx = 0, held = 0, k = 0, s0, d0, a0, low_run = 0;
        bit acc, seen_done = 1'b0, hold;
        logic prev_head;
        s0 = shift_cnt; d0 = done_cnt; a0 = acc_cnt;
        g_first_en = -1; g_last_en = -1; g_done_k = -1; g_lows = 0;
        g_timeout = 0; g_head_moved = 0; g_busy_at_done = 0; g_pre_en = 0;
        g_rst_snap = '1;
        @(negedge prog_clk);
        start = 1'b1; verify_en = ver;
        @(negedge prog_clk);
        start = 1'b0; verify_en = 1'b0;
        g_cnt_start  = mismatch_cnt;
        g_fail_start = verify_fail;
        prev_head = ccff_head;
        while (!seen_done) begin
            if (k == reset_at) begin
                g_pre_en   = config_enable;
                pReset_n   = 1'b0;
                word_valid = 1'b0;
                #1;
                g_rst_snap = {busy, config_enable, ccff_head, done, word_ready};
                break;
            end
            hold = (idx == hold_idx) && word_ready && (held < hold_len);
            if (hold) held++;
            if (idx < nwords && !hold && ($urandom_range(0, 99) >= gap_pct)) begin
                word_valid = 1'b1;
                word_data  = op_words[idx];
            end else begin
                word_valid = 1'b0;
                word_data  = $urandom;
            end
            start     = (k == restart_at);
            verify_en = (k == restart_at);
            #1;
            acc = word_valid && word_ready;
            @(posedge prog_clk);
            if (acc) idx++;
            @(negedge prog_clk);
            k++;
            start = 1'b0; verify_en = 1'b0;
            if (config_enable) begin
                if (g_first_en < 0) g_first_en = k;
                else g_lows += low_run;
                low_run   = 0;
                g_last_en = k;
            end else if (g_first_en >= 0) begin
                low_run++;
                if (ccff_head !== prev_head) g_head_moved = 1;
            end
            prev_head = ccff_head;
            if (done) begin
                seen_done      = 1'b1;
                g_done_k       = k;
                g_busy_at_done = busy;
            end
            if (k > 400) begin
                g_timeout = 1;
                break;
            end
        end
        word_valid = 1'b0;
        @(negedge prog_clk);
        g_shifts = shift_cnt - s0;
        g_dones  = done_cnt - d0;
        g_acc    = acc_cnt - a0;
    endtask

    task automatic set_t1_words();
        op_words[0] = 32'hA5A5A5A5; op_words[1] = 32'h000000FF;
        op_words[2] = 32'hA5A5A5A5; op_words[3] = 32'h000000FF;
    endtask

    task automatic test_reset();
        pReset_n = 1'b0; word_valid = 1'b1; word_data = 32'hFFFFFFFF;
        repeat (2) @(negedge prog_clk);
        checks++;
        if ({word_ready, ccff_head, config_enable, busy, done, verify_fail, mismatch_cnt} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {word_ready, ccff_head, config_enable, busy, done, verify_fail, mismatch_cnt});
        end
        pReset_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++;
        if (word_ready !== 1'b0 || acc_cnt != 0) begin
            errors++;
            $display("FAIL idle_no_accept: ready %b accepted %0d expected 0/0", word_ready, acc_cnt);
        end
        word_valid = 1'b0;
    endtask

    task automatic test_load_only();
        set_t1_words();
        drive_op(1'b0, 2, -1, 0, 0, -1, -1);
        checks++;
        if (g_timeout || g_shifts != 40 || g_acc != 2 || g_dones != 1) begin
            errors++;
            $display("FAIL t1_counts: shifts %0d acc %0d dones %0d timeout %0d expected 40/2/1/0",
                     g_shifts, g_acc, g_dones, g_timeout);
        end
        checks++;
        if (chain !== 40'hFF_A5A5A5A5) begin
            errors++;
            $display("FAIL t1_image: got %h expected ffa5a5a5a5", chain);
        end
        checks++;
        if (g_first_en != 2 || verify_fail !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency: first enable after %0d edges fail %b expected 2/0", g_first_en, verify_fail);
        end
    endtask

    task automatic test_verify_clean();
        set_t1_words();
        drive_op(1'b1, 4, -1, 0, 0, -1, -1);
        checks++;
        if (g_timeout || g_shifts != 80 || g_acc != 4 || g_dones != 1) begin
            errors++;
            $display("FAIL t2_counts: shifts %0d acc %0d dones %0d expected 80/4/1", g_shifts, g_acc, g_dones);
        end
        checks++;
        if (mismatch_cnt !== 2'd0 || verify_fail !== 1'b0) begin
            errors++;
            $display("FAIL t2_result: cnt %0d fail %b expected 0/0", mismatch_cnt, verify_fail);
        end
        checks++;
        if (g_done_k != g_last_en + 1 || g_busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL t2_done_timing: done at %0d last enable %0d busy %b expected last+1, busy 0",
                     g_done_k, g_last_en, g_busy_at_done);
        end
    endtask

    task automatic test_verify_flip();
        set_t1_words();
        fork
            drive_op(1'b1, 4, -1, 0, 0, -1, -1);
            begin
                int s0 = shift_cnt, t = 0;
                while (shift_cnt - s0 < 40 && t < 300) begin
                    @(negedge prog_clk);
                    t++;
                end
                flip_token++;
            end
        join
        checks++;
        if (mismatch_cnt !== 2'd1 || verify_fail !== 1'b1) begin
            errors++;
            $display("FAIL t3_flip: cnt %0d fail %b expected 1/1", mismatch_cnt, verify_fail);
        end
        checks++;
        if (chain !== exp_image(1)) begin
            errors++;
            $display("FAIL t3_image: got %h expected %h", chain, exp_image(1));
        end
        drive_op(1'b0, 2, -1, 0, 0, -1, -1);
        checks++;
        if (g_cnt_start !== 2'd0 || g_fail_start !== 1'b0 || verify_fail !== 1'b0) begin
            errors++;
            $display("FAIL t3_clear_on_start: cnt %0d fail %b expected 0/0", g_cnt_start, g_fail_start);
        end
    endtask

    task automatic test_stall();
        set_t1_words();
        drive_op(1'b0, 2, 1, 5, 0, -1, -1);
        checks++;
        if (g_timeout || g_lows != 5 || g_head_moved) begin
            errors++;
            $display("FAIL t4_stall: idle gaps %0d head moved %0d expected 5/0", g_lows, g_head_moved);
        end
        checks++;
        if (chain !== 40'hFF_A5A5A5A5 || g_shifts != 40) begin
            errors++;
            $display("FAIL t4_image: got %h shifts %0d expected ffa5a5a5a5/40", chain, g_shifts);
        end
    endtask

    task automatic test_saturate();
        set_t1_words();
        corrupt_all = 1'b1;
        drive_op(1'b1, 4, -1, 0, 0, -1, -1);
        corrupt_all = 1'b0;
        checks++;
        if (mismatch_cnt !== 2'd3 || verify_fail !== 1'b1) begin
            errors++;
            $display("FAIL t5_saturate: cnt %0d fail %b expected 3/1", mismatch_cnt, verify_fail);
        end
    endtask

    task automatic test_async_reset();
        op_words[0] = 32'hFFFFFFFF; op_words[1] = 32'hFFFFFFFF;
        drive_op(1'b0, 2, -1, 0, 0, -1, 10);
        checks++;
        if (g_pre_en !== 1'b1 || g_rst_snap !== 5'd0) begin
            errors++;
            $display("FAIL t6_reset_mid_load: pre enable %b busy/en/head/done/ready %b expected 1/00000",
                     g_pre_en, g_rst_snap);
        end
        @(negedge prog_clk);
        pReset_n = 1'b1;
        set_t1_words();
        drive_op(1'b0, 2, -1, 0, 0, -1, -1);
        checks++;
        if (chain !== 40'hFF_A5A5A5A5 || g_acc != 2) begin
            errors++;
            $display("FAIL t6_restart_image: got %h acc %0d expected ffa5a5a5a5/2", chain, g_acc);
        end
    endtask

    task automatic test_start_while_busy();
        set_t1_words();
        drive_op(1'b0, 4, -1, 0, 0, 10, -1);
        checks++;
        if (g_timeout || g_shifts != 40 || g_acc != 2 || g_dones != 1 || chain !== 40'hFF_A5A5A5A5) begin
            errors++;
            $display("FAIL t6_start_ignored: shifts %0d acc %0d dones %0d image %h expected 40/2/1/ffa5a5a5a5",
                     g_shifts, g_acc, g_dones, chain);
        end
    endtask

    task automatic test_random_ops();
        for (int it = 0; it < 6; it++) begin
            bit ver = 1'($urandom_range(0, 1));
            int mode = $urandom_range(0, 2);
            int nm = 0;
            op_words[0] = $urandom; op_words[1] = $urandom;
            op_words[2] = op_words[0]; op_words[3] = op_words[1];
            op_words[3][31:8] = 24'($urandom);
            if (mode == 1) op_words[2][$urandom_range(0, 31)] ^= 1'b1;
            if (mode == 2) begin op_words[2] = $urandom; op_words[3] = $urandom; end
            for (int i = 0; i < L; i++) if (stream_bit(0, i) != stream_bit(1, i)) nm++;
            if (!ver) nm = 0;
            drive_op(ver, ver ? 4 : 2, -1, 0, 20, -1, -1);
            checks++;
            if (g_timeout || g_shifts != (ver ? 2 * L : L) || g_acc != (ver ? 4 : 2) || g_dones != 1) begin
                errors++;
                $display("FAIL rand_counts[%0d]: shifts %0d acc %0d dones %0d verify %0d",
                         it, g_shifts, g_acc, g_dones, ver);
            end
            checks++;
            if (chain !== exp_image(ver ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_image[%0d]: got %h expected %h", it, chain, exp_image(ver ? 1 : 0));
            end
            checks++;
            if (int'(mismatch_cnt) != sat_cnt(nm) || verify_fail !== (nm > 0)) begin
                errors++;
                $display("FAIL rand_verify[%0d]: cnt %0d fail %b expected %0d/%0d",
                         it, mismatch_cnt, verify_fail, sat_cnt(nm), (nm > 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_verify_clean();
        test_verify_flip();
        test_stall();
        test_saturate();
        test_async_reset();
        test_start_while_busy();
        test_random_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
